// File: rtl/div_ctl_if.sv
// rtl/div_ctl_if.sv - request/response handshakes and divider-core link for div_ctl
interface div_ctl_if #(
  parameter int DSZ = 32
);
  logic           req_valid;
  logic           req_ready;
  logic           req_sgn;
  logic [DSZ-1:0] req_a;
  logic [DSZ-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DSZ-1:0] rsp_q;
  logic [DSZ-1:0] rsp_r;
  logic           rsp_dbz;
  logic           div_start;
  logic [DSZ-1:0] div_x;
  logic [DSZ-1:0] div_y;
  logic [DSZ-1:0] div_q;
  logic [DSZ-1:0] div_r;

  modport slave (
    input  req_valid, req_sgn, req_a, req_b, rsp_ready, div_q, div_r,
    output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, div_start, div_x, div_y
  );

  modport master (
    output req_valid, req_sgn, req_a, req_b, rsp_ready, div_q, div_r,
    input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, div_start, div_x, div_y
  );
endinterface

// File: rtl/div_ctl.sv
// rtl/div_ctl.sv - sequencer for the iterative shift-subtract divider core
// Optional floored signed division: define DIV_FLOORED_EN.
module div_ctl #(
  parameter int DSZ = 32
) (
  input logic        clk,
  input logic        rst_n,
  div_ctl_if.slave   bus
);
  localparam int CW = $clog2(DSZ);
  localparam logic [CW-1:0] CNT_LAST = CW'(DSZ - 1);

  typedef enum logic [2:0] {IDLE, START, RUN, FIX, DONE} state_e;

  state_e         state_q;
  logic           req_ready_q;
  logic           rsp_valid_q;
  logic           rsp_dbz_q;
  logic           div_start_q;
  logic           sa_q;
  logic           sb_q;
  logic [CW-1:0]  cnt_q;
  logic [DSZ-1:0] div_x_q;
  logic [DSZ-1:0] div_y_q;
  logic [DSZ-1:0] rsp_q_q;
  logic [DSZ-1:0] rsp_r_q;
`ifdef DIV_FLOORED_EN
  logic [DSZ-1:0] b_q;
`endif

  logic           sa_d;
  logic           sb_d;
  logic [DSZ-1:0] q_d;
  logic [DSZ-1:0] r_d;

  always_comb begin
    sa_d = bus.req_a[DSZ-1] & bus.req_sgn;
    sb_d = bus.req_b[DSZ-1] & bus.req_sgn;
    q_d  = (sa_q ^ sb_q) ? -bus.div_q : bus.div_q;
    r_d  = sa_q ? -bus.div_r : bus.div_r;
`ifdef DIV_FLOORED_EN
    // Pull a nonzero remainder over to the divisor's side of zero.
    if ((r_d != '0) && (sa_q != sb_q)) begin
      q_d = q_d - DSZ'(1);
      r_d = r_d + b_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dbz_q   <= 1'b0;
      div_start_q <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      cnt_q       <= '0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
`ifdef DIV_FLOORED_EN
      b_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            req_ready_q <= 1'b0;
`ifdef DIV_FLOORED_EN
            b_q         <= bus.req_b;
`endif
            if (bus.req_b == '0) begin
              rsp_q_q     <= '1;
              rsp_r_q     <= bus.req_a;
              rsp_dbz_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              div_x_q     <= sa_d ? -bus.req_a : bus.req_a;
              div_y_q     <= sb_d ? -bus.req_b : bus.req_b;
              div_start_q <= 1'b1;
              state_q     <= START;
            end
          end
        end
        START: begin
          div_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= FIX;
        end
        FIX: begin
          rsp_q_q     <= q_d;
          rsp_r_q     <= r_d;
          rsp_dbz_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign bus.req_ready = req_ready_q & rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_dbz   = rsp_dbz_q;
  assign bus.div_start = div_start_q;
  assign bus.div_x     = div_x_q;
  assign bus.div_y     = div_y_q;
endmodule

// File: doc/div_ctl.md
# div_ctl

Sequencer that sits directly upstream of the iterative shift-subtract divider core. It accepts division requests over a valid/ready handshake and converts signed operands to magnitudes. It launches the core with a one-cycle start pulse, counts its DSZ iterations, applies sign and rounding correction, and returns quotient/remainder over a second valid/ready handshake. It also short-circuits divide-by-zero without starting the core.

## Interface
- DSZ, 32, operand/result width (≥ 4)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted when both high
- req_sgn  in  1  1 = signed (two's complement), 0 = unsigned
- req_a  in  DSZ  dividend
- req_b  in  DSZ  divisor
- rsp_valid  out  1  result held stable until accepted
- rsp_ready  in  1  consumer takes result
- rsp_q  out  DSZ  quotient
- rsp_r  out  DSZ  remainder
- rsp_dbz  out  1  divide-by-zero flag for this result
- div_start  out  1  one-cycle active-high start to core (core's rst)
- div_x  out  DSZ  magnitude dividend to core, registered
- div_y  out  DSZ  magnitude divisor to core, registered
- div_q  in  DSZ  core quotient
- div_r  in  DSZ  core remainder

## Operation
- States: IDLE, START, RUN, FIX, DONE.
- IDLE: req_ready=1. On req_valid: latch sgn, sign bits sa=a[DSZ-1]&sgn and sb=b[DSZ-1]&sgn, and b.
  - If b==0: go to DONE with rsp_q=all-ones, rsp_r=req_a, rsp_dbz=1.
  - Otherwise set div_x=sa?-a:a and div_y=sb?-b:b, then go to START.
- START: div_start=1 for exactly one cycle. Iteration counter cleared. Go to RUN.
- RUN: exactly DSZ cycles; counter increments each cycle. Leave when counter reaches DSZ-1.
- FIX: sample div_q/div_r.
  - q = (sa^sb) ? -div_q : div_q.
  - r = sa ? -div_r : div_r.
  - Floored adjustment applies only when DIV_FLOORED_EN is defined (see Configuration).
  - Register into rsp_q/rsp_r, rsp_dbz=0, then go to DONE.
- DONE: rsp_valid=1. Outputs stable until rsp_valid&rsp_ready, then go to IDLE.
- Negation is DSZ-bit two's complement, wrapping. MIN/-1 yields rsp_q=MIN, rsp_r=0, no flag.
- div_x/div_y hold their value from START through FIX.
- Reset values: state IDLE, req_ready=0 while rst_n low and 1 on the first cycle after; rsp_valid=0, rsp_q=0, rsp_r=0, rsp_dbz=0, div_start=0, div_x=0, div_y=0, counter 0.
- Reset mid-operation aborts immediately. The core is not pulsed, no response is produced, and the next request starts cleanly.

## Timing
- Accept at edge T. START is cycle T+1. RUN covers T+2..T+DSZ+1. FIX is T+DSZ+2. rsp_valid=1 from T+DSZ+3, i.e. DSZ+3 cycles from accept.
- Divide-by-zero: rsp_valid=1 at T+1.
- Response release: with rsp_ready held high, rsp_valid drops one cycle after rising. req_ready rises the same cycle, giving a throughput of one op per DSZ+4 cycles.
- Backpressure: rsp_ready low stalls indefinitely in DONE. req_ready stays 0 and outputs are unchanged.
- req_ready is 0 in every state except IDLE. Requests presented in other states are ignored and not queued.
- div_start is never asserted outside START.

## Configuration
- DIV_FLOORED_EN defined: signed results use floored division. When r≠0 and sa≠sb, FIX additionally applies q=q-1 and r=r+b (original divisor). The remainder then carries the divisor's sign.
- DIV_FLOORED_EN undefined: signed results use symmetric (truncating) division. The remainder carries the dividend's sign.
- Unsigned ops and divide-by-zero behave identically in both builds. Latency is unchanged.

## Test plan
- Unsigned 100/7, DSZ=32 → q=14, r=2, dbz=0. rsp_valid exactly 35 cycles after accept. div_start high for exactly one cycle.
- Signed -7/2 → without macro q=-3, r=-1; with DIV_FLOORED_EN q=-4, r=1. Signed 7/-2 → q=-3, r=1 / q=-4, r=-1.
- Divide by zero, a=0x1234 → rsp_valid next cycle, q=0xFFFFFFFF, r=0x1234, dbz=1. div_start never asserted.
- Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0, dbz=0. Unsigned same operands → q=0, r=0x80000000.
- Hold rsp_ready=0 for 10 cycles in DONE → rsp_* stable and req_ready=0. A new req_valid is ignored until the handshake, then accepted.
- Drop rst_n for one cycle mid-RUN → next cycle IDLE with req_ready=1 and rsp_valid=0. A following 9/3 returns q=3, r=0 with the normal latency.
